// File: rtl/rpn_pkg.sv
// Shared types and constants for the RPN calculator's operator-stack arbiter.
// Opcodes, arbiter FSM states, and ASCII codes of the expression characters.
package rpn_pkg;

  localparam int STACK_DEPTH = 16;
  localparam int STACK_OCC_W = 5;

  typedef enum logic [1:0] {
    OP_NONE = 2'b00,
    OP_PUSH = 2'b01,
    OP_POP  = 2'b10,
    OP_PEEK = 2'b11
  } op_e;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    WAIT  = 2'd2,
    RESP  = 2'd3
  } state_e;

  localparam logic [7:0] CH_LPAREN = 8'h28;
  localparam logic [7:0] CH_RPAREN = 8'h29;
  localparam logic [7:0] CH_ZERO   = 8'h30;
  localparam logic [7:0] CH_MINUS  = 8'h2d;
  localparam logic [7:0] CH_PLUS   = 8'h2b;
  localparam logic [7:0] CH_STAR   = 8'h2a;
  localparam logic [7:0] CH_SLASH  = 8'h2f;
  localparam logic [7:0] CH_EQ     = 8'h3d;

endpackage

// File: rtl/rr_pick2.sv
// Combinational two-way round-robin picker: bit 0 is port A, bit 1 is port B.
// last=1 means B was granted last, so A wins a tie.
module rr_pick2 (
  input  logic [1:0] req,
  input  logic       last,
  output logic [1:0] gnt
);

  always_comb begin
    gnt = 2'b00;
    case (req)
      2'b01:   gnt = 2'b01;
      2'b10:   gnt = 2'b10;
      2'b11:   gnt = last ? 2'b01 : 2'b10;
      default: gnt = 2'b00;
    endcase
  end

endmodule

// File: rtl/stack_arbiter.sv
// Arbitrates two requesters (A: infix->RPN, B: evaluator) onto one 8-bit stack.
// Optional STACK_ARB_LOCK_EN lets the granted port keep the stack across transactions.
module stack_arbiter
  import rpn_pkg::*;
#(
  parameter int DEPTH = STACK_DEPTH,
  parameter int OCC_W = STACK_OCC_W
) (
  input  logic             CLK,
  input  logic             RST_N,
  input  logic             A_STB,
  input  logic [1:0]       A_OP,
  input  logic [7:0]       A_DAT,
  input  logic             A_LOCK,
  output logic             A_ACK,
  output logic [7:0]       A_RDAT,
  output logic             A_ERR,
  input  logic             B_STB,
  input  logic [1:0]       B_OP,
  input  logic [7:0]       B_DAT,
  input  logic             B_LOCK,
  output logic             B_ACK,
  output logic [7:0]       B_RDAT,
  output logic             B_ERR,
  output logic             S_PUSH_STB,
  output logic [7:0]       S_PUSH_DAT,
  input  logic             S_PUSH_ACK,
  input  logic             S_POP_STB,
  input  logic [7:0]       S_POP_DAT,
  output logic             S_POP_ACK,
  output logic [OCC_W-1:0] OCC,
  output logic [1:0]       DBG_STATE
);

  // Handshake: a requester holds STB/OP/DAT until it sees its one-cycle ACK;
  // S_PUSH_STB is held until S_PUSH_ACK is sampled high; S_POP_ACK is a single pulse.
  localparam logic [OCC_W-1:0] OCC_FULL = OCC_W'(DEPTH);
  localparam logic [OCC_W-1:0] OCC_ONE  = OCC_W'(1);

  state_e           state_q, state_d;
  logic             gnt_b_q, gnt_b_d;
  logic [1:0]       op_q, op_d;
  logic [7:0]       dat_q, dat_d;
  logic [7:0]       rdat_q, rdat_d;
  logic             err_q, err_d;
  logic             last_q, last_d;
  logic [OCC_W-1:0] occ_q, occ_d;
  logic             push_stb_q, push_stb_d;
  logic [7:0]       push_dat_q, push_dat_d;
  logic             pop_ack_q, pop_ack_d;
  logic             a_ack_q, a_ack_d, b_ack_q, b_ack_d;
  logic             a_err_q, a_err_d, b_err_q, b_err_d;
  logic [7:0]       a_rdat_q, a_rdat_d, b_rdat_q, b_rdat_d;

  logic       gap;
  logic [1:0] req, gnt;
  logic       grant_b, any_gnt, reject;
  logic [1:0] sel_op;
  logic [7:0] sel_dat;

  // An ACK still showing means the requester has not yet dropped STB: skip that cycle.
  assign gap = a_ack_q | b_ack_q;

`ifdef STACK_ARB_LOCK_EN
  logic locked_q, locked_d, lock_b_q, lock_b_d, lock_s;
  assign lock_s = gnt_b_q ? B_LOCK : A_LOCK;
  assign req = ~{2{gap}} & (locked_q ? (lock_b_q ? {B_STB, 1'b0} : {1'b0, A_STB})
                                     : {B_STB, A_STB});
`else
  logic unused_lock;
  assign unused_lock = A_LOCK ^ B_LOCK;
  assign req = ~{2{gap}} & {B_STB, A_STB};
`endif

  rr_pick2 u_pick (
    .req  (req),
    .last (last_q),
    .gnt  (gnt)
  );

  assign grant_b = gnt[1];
  assign any_gnt = |gnt;
  assign sel_op  = grant_b ? B_OP : A_OP;
  assign sel_dat = grant_b ? B_DAT : A_DAT;
  assign reject  = (sel_op == OP_PUSH) ? (occ_q == OCC_FULL)
                                       : ((occ_q == '0) || !S_POP_STB);

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      state_q    <= IDLE;
      gnt_b_q    <= 1'b0;
      op_q       <= 2'b00;
      dat_q      <= 8'h00;
      rdat_q     <= 8'h00;
      err_q      <= 1'b0;
      last_q     <= 1'b1;
      occ_q      <= '0;
      push_stb_q <= 1'b0;
      push_dat_q <= 8'h00;
      pop_ack_q  <= 1'b0;
      a_ack_q    <= 1'b0;
      b_ack_q    <= 1'b0;
      a_err_q    <= 1'b0;
      b_err_q    <= 1'b0;
      a_rdat_q   <= 8'h00;
      b_rdat_q   <= 8'h00;
`ifdef STACK_ARB_LOCK_EN
      locked_q   <= 1'b0;
      lock_b_q   <= 1'b0;
`endif
    end else begin
      state_q    <= state_d;
      gnt_b_q    <= gnt_b_d;
      op_q       <= op_d;
      dat_q      <= dat_d;
      rdat_q     <= rdat_d;
      err_q      <= err_d;
      last_q     <= last_d;
      occ_q      <= occ_d;
      push_stb_q <= push_stb_d;
      push_dat_q <= push_dat_d;
      pop_ack_q  <= pop_ack_d;
      a_ack_q    <= a_ack_d;
      b_ack_q    <= b_ack_d;
      a_err_q    <= a_err_d;
      b_err_q    <= b_err_d;
      a_rdat_q   <= a_rdat_d;
      b_rdat_q   <= b_rdat_d;
`ifdef STACK_ARB_LOCK_EN
      locked_q   <= locked_d;
      lock_b_q   <= lock_b_d;
`endif
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (any_gnt) state_d = reject ? RESP : ISSUE;
      ISSUE:   state_d = (op_q == OP_PUSH) ? WAIT : RESP;
      WAIT:    if (S_PUSH_ACK) state_d = RESP;
      RESP:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    gnt_b_d    = gnt_b_q;
    op_d       = op_q;
    dat_d      = dat_q;
    rdat_d     = rdat_q;
    err_d      = err_q;
    last_d     = last_q;
    occ_d      = occ_q;
    push_stb_d = push_stb_q;
    push_dat_d = push_dat_q;
    pop_ack_d  = 1'b0;
    a_ack_d    = 1'b0;
    b_ack_d    = 1'b0;
    a_err_d    = 1'b0;
    b_err_d    = 1'b0;
    a_rdat_d   = a_rdat_q;
    b_rdat_d   = b_rdat_q;
`ifdef STACK_ARB_LOCK_EN
    locked_d   = locked_q;
    lock_b_d   = lock_b_q;
`endif
    case (state_q)
      IDLE: if (any_gnt) begin
        gnt_b_d = grant_b;
        op_d    = sel_op;
        dat_d   = sel_dat;
        rdat_d  = S_POP_DAT;
        err_d   = reject;
      end
      ISSUE: begin
        if (op_q == OP_PUSH) begin
          push_stb_d = 1'b1;
          push_dat_d = dat_q;
        end else if (op_q == OP_POP) begin
          pop_ack_d = 1'b1;
          if (occ_q != '0) occ_d = occ_q - OCC_ONE;
        end
      end
      WAIT: if (S_PUSH_ACK) begin
        push_stb_d = 1'b0;
        if (occ_q != OCC_FULL) occ_d = occ_q + OCC_ONE;
      end
      RESP: begin
        if (gnt_b_q) begin
          b_ack_d  = 1'b1;
          b_err_d  = err_q;
          b_rdat_d = rdat_q;
        end else begin
          a_ack_d  = 1'b1;
          a_err_d  = err_q;
          a_rdat_d = rdat_q;
        end
`ifdef STACK_ARB_LOCK_EN
        locked_d = lock_s;
        lock_b_d = gnt_b_q;
        if (!lock_s) last_d = gnt_b_q;
`else
        last_d = gnt_b_q;
`endif
      end
      default: ;
    endcase
  end

  assign A_ACK      = a_ack_q;
  assign A_ERR      = a_err_q;
  assign A_RDAT     = a_rdat_q;
  assign B_ACK      = b_ack_q;
  assign B_ERR      = b_err_q;
  assign B_RDAT     = b_rdat_q;
  assign S_PUSH_STB = push_stb_q;
  assign S_PUSH_DAT = push_dat_q;
  assign S_POP_ACK  = pop_ack_q;
  assign OCC        = occ_q;
  assign DBG_STATE  = state_q;

endmodule

// File: tb/tb_stack_arbiter.sv
// Randomized scoreboard bench for stack_arbiter with a behavioural stack/arbiter model.
// Default build (STACK_ARB_LOCK_EN undefined): LOCK inputs toggle and must be ignored.
module tb_stack_arbiter;
  import rpn_pkg::*;

  localparam int DEPTH = 16;
  localparam int OCC_W = 5;

  logic             CLK = 1'b0;
  logic             RST_N = 1'b0;
  logic             A_STB = 1'b0, B_STB = 1'b0;
  logic [1:0]       A_OP = 2'b00, B_OP = 2'b00;
  logic [7:0]       A_DAT = 8'h00, B_DAT = 8'h00;
  logic             A_LOCK = 1'b0, B_LOCK = 1'b0;
  logic             A_ACK, B_ACK, A_ERR, B_ERR;
  logic [7:0]       A_RDAT, B_RDAT;
  logic             S_PUSH_STB, S_POP_ACK;
  logic [7:0]       S_PUSH_DAT;
  logic             S_PUSH_ACK = 1'b0, S_POP_STB = 1'b0;
  logic [7:0]       S_POP_DAT = 8'h00;
  logic [OCC_W-1:0] OCC;
  logic [1:0]       DBG_STATE;

  int checks = 0;
  int failures = 0;
  // Entry: [15] port (1=B), [14:10] OCC after, [8] err, [7:0] rdat.
  logic [15:0] exp_q[$];
  logic [7:0]  mstk[$];
  bit          m_last = 1'b1;
  logic [7:0]  stk[$];
  int          push_delay = 2;
  int          ack_cnt = 0;
  int          push_stb_cycles = 0;
  int          pop_ack_pulses = 0;

  always #5 CLK = ~CLK;

  stack_arbiter dut (
    .CLK(CLK), .RST_N(RST_N),
    .A_STB(A_STB), .A_OP(A_OP), .A_DAT(A_DAT), .A_LOCK(A_LOCK),
    .A_ACK(A_ACK), .A_RDAT(A_RDAT), .A_ERR(A_ERR),
    .B_STB(B_STB), .B_OP(B_OP), .B_DAT(B_DAT), .B_LOCK(B_LOCK),
    .B_ACK(B_ACK), .B_RDAT(B_RDAT), .B_ERR(B_ERR),
    .S_PUSH_STB(S_PUSH_STB), .S_PUSH_DAT(S_PUSH_DAT), .S_PUSH_ACK(S_PUSH_ACK),
    .S_POP_STB(S_POP_STB), .S_POP_DAT(S_POP_DAT), .S_POP_ACK(S_POP_ACK),
    .OCC(OCC), .DBG_STATE(DBG_STATE)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  // Attached stack: acks a push push_delay cycles after seeing STB, shares RST_N.
  initial begin : stack_model
    logic       do_push, do_pop, stb_seen;
    logic [7:0] pdat;
    forever begin
      @(negedge CLK);
      do_push  = S_PUSH_STB && S_PUSH_ACK;
      do_pop   = S_POP_ACK;
      stb_seen = S_PUSH_STB;
      pdat     = S_PUSH_DAT;
      @(posedge CLK or negedge RST_N);
      if (!RST_N) begin
        stk.delete();
        ack_cnt    = 0;
        S_PUSH_ACK = 1'b0;
      end else begin
        #1;
        if (do_push) begin
          stk.push_back(pdat);
          S_PUSH_ACK = 1'b0;
          ack_cnt    = 0;
        end else if (stb_seen) begin
          ack_cnt++;
          if (ack_cnt >= push_delay) S_PUSH_ACK = 1'b1;
        end
        if (do_pop && stk.size() > 0) void'(stk.pop_back());
      end
      S_POP_STB = (stk.size() > 0);
      S_POP_DAT = (stk.size() > 0) ? stk[$] : 8'h00;
    end
  end

  always @(negedge CLK) begin
    if (S_PUSH_STB) push_stb_cycles++;
    if (S_POP_ACK) pop_ack_pulses++;
  end

  initial begin : monitor
    logic [15:0] e;
    forever begin
      @(negedge CLK);
      if (RST_N && (A_ACK || B_ACK)) begin
        if (A_ACK && B_ACK) begin
          checks++; failures++;
          $display("FAIL dual_ack: got A_ACK=1 B_ACK=1 expected one ACK");
        end else if (exp_q.size() == 0) begin
          checks++; failures++;
          $display("FAIL spurious_ack: got ACK on port %s expected none", A_ACK ? "A" : "B");
        end else begin
          e = exp_q.pop_front();
          check("ack_port", 32'(B_ACK), 32'(e[15]));
          check("ack_occ", 32'(OCC), 32'(e[14:10]));
          check("ack_err", 32'(B_ACK ? B_ERR : A_ERR), 32'(e[8]));
          check("ack_rdat", 32'(B_ACK ? B_RDAT : A_RDAT), 32'(e[7:0]));
          check("other_err", 32'(B_ACK ? A_ERR : B_ERR), 32'(0));
        end
      end
    end
  end

  // Reference: a transaction sees the stack top as RDAT, errors on full push or empty pop/peek.
  function automatic logic [15:0] serve(input bit port, input logic [1:0] op,
                                        input logic [7:0] dat, output bit err);
    logic [7:0] top;
    top = (mstk.size() > 0) ? mstk[$] : 8'h00;
    err = 1'b0;
    case (op)
      OP_PUSH: if (mstk.size() >= DEPTH) err = 1'b1; else mstk.push_back(dat);
      OP_POP:  if (mstk.size() == 0) err = 1'b1; else void'(mstk.pop_back());
      default: if (mstk.size() == 0) err = 1'b1;
    endcase
    return {port, 5'(mstk.size()), 1'b0, err, top};
  endfunction

  function automatic int lat_of(input logic [1:0] op, input bit err);
    if (err) return 1;
    return (op == OP_PUSH) ? 3 + push_delay : 2;
  endfunction

  function automatic logic lock_val();
`ifdef STACK_ARB_LOCK_EN
    return 1'b0;
`else
    return 1'($urandom_range(0, 1));
`endif
  endfunction

  task automatic do_round(input bit a_en, input logic [1:0] a_op, input logic [7:0] a_dat,
                          input bit b_en, input logic [1:0] b_op, input logic [7:0] b_dat);
    bit a_err_m, b_err_m, pend_a, pend_b, drop_a, drop_b;
    int a_exp, b_exp, a_lat, b_lat, e;
    a_exp = -1; b_exp = -1;
    if (a_en && b_en) begin
      if (!m_last) begin
        exp_q.push_back(serve(1'b1, b_op, b_dat, b_err_m));
        b_exp = lat_of(b_op, b_err_m);
        exp_q.push_back(serve(1'b0, a_op, a_dat, a_err_m));
        a_exp = b_exp + 2 + lat_of(a_op, a_err_m);
        m_last = 1'b0;
      end else begin
        exp_q.push_back(serve(1'b0, a_op, a_dat, a_err_m));
        a_exp = lat_of(a_op, a_err_m);
        exp_q.push_back(serve(1'b1, b_op, b_dat, b_err_m));
        b_exp = a_exp + 2 + lat_of(b_op, b_err_m);
        m_last = 1'b1;
      end
    end else if (a_en) begin
      exp_q.push_back(serve(1'b0, a_op, a_dat, a_err_m));
      a_exp = lat_of(a_op, a_err_m);
      m_last = 1'b0;
    end else if (b_en) begin
      exp_q.push_back(serve(1'b1, b_op, b_dat, b_err_m));
      b_exp = lat_of(b_op, b_err_m);
      m_last = 1'b1;
    end
    A_STB = a_en; A_OP = a_op; A_DAT = a_dat; A_LOCK = lock_val();
    B_STB = b_en; B_OP = b_op; B_DAT = b_dat; B_LOCK = lock_val();
    pend_a = a_en; pend_b = b_en; drop_a = 1'b0; drop_b = 1'b0;
    a_lat = -1; b_lat = -1; e = -1;
    while ((pend_a || pend_b) && e < 200) begin
      @(posedge CLK); e++; #1;
      if (drop_a) begin A_STB = 1'b0; drop_a = 1'b0; end
      if (drop_b) begin B_STB = 1'b0; drop_b = 1'b0; end
      @(negedge CLK);
      if (pend_a && A_ACK) begin a_lat = e; pend_a = 1'b0; drop_a = 1'b1; end
      if (pend_b && B_ACK) begin b_lat = e; pend_b = 1'b0; drop_b = 1'b1; end
    end
    if (pend_a || pend_b) begin
      checks++; failures++;
      $display("FAIL round_timeout: got no ACK after %0d cycles expected ACK", e);
    end
    @(posedge CLK); #1;
    A_STB = 1'b0; B_STB = 1'b0;
    if (a_en && !pend_a) check("a_latency", 32'(a_lat), 32'(a_exp));
    if (b_en && !pend_b) check("b_latency", 32'(b_lat), 32'(b_exp));
  endtask

  task automatic check_outputs_zero(input string tag);
    check({tag, "_a_ack"}, 32'(A_ACK), 32'(0));
    check({tag, "_b_ack"}, 32'(B_ACK), 32'(0));
    check({tag, "_a_err"}, 32'(A_ERR), 32'(0));
    check({tag, "_b_err"}, 32'(B_ERR), 32'(0));
    check({tag, "_a_rdat"}, 32'(A_RDAT), 32'(0));
    check({tag, "_b_rdat"}, 32'(B_RDAT), 32'(0));
    check({tag, "_push_stb"}, 32'(S_PUSH_STB), 32'(0));
    check({tag, "_push_dat"}, 32'(S_PUSH_DAT), 32'(0));
    check({tag, "_pop_ack"}, 32'(S_POP_ACK), 32'(0));
    check({tag, "_occ"}, 32'(OCC), 32'(0));
    check({tag, "_state"}, 32'(DBG_STATE), 32'(IDLE));
  endtask

  initial begin : watchdog
    #500000;
    $display("FAIL watchdog: got no finish expected end of test");
    $fatal(1, "watchdog expired");
  end

  initial begin : main
    int s0;
    repeat (3) @(posedge CLK);
    @(negedge CLK);
    check_outputs_zero("reset");
    @(posedge CLK); #3 RST_N = 1'b1;
    @(posedge CLK); #1;

    s0 = pop_ack_pulses;
    do_round(1'b0, OP_NONE, 8'h00, 1'b1, OP_POP, 8'h00);
    check("empty_pop_no_s_pop_ack", 32'(pop_ack_pulses - s0), 32'(0));

    do_round(1'b1, OP_PUSH, CH_STAR, 1'b1, OP_PEEK, 8'h00);
    do_round(1'b1, OP_PEEK, 8'h00, 1'b0, OP_NONE, 8'h00);
    do_round(1'b1, OP_PEEK, 8'h00, 1'b1, OP_PEEK, 8'h00);
    do_round(1'b0, OP_NONE, 8'h00, 1'b1, OP_POP, 8'h00);

    push_delay = 2;
    s0 = push_stb_cycles;
    do_round(1'b1, OP_PUSH, CH_PLUS, 1'b0, OP_NONE, 8'h00);
    check("push_stb_cycles", 32'(push_stb_cycles - s0), 32'(3));
    check("occ_after_push", 32'(OCC), 32'(1));

    for (int i = 0; i < DEPTH - 1; i++) begin
      push_delay = $urandom_range(1, 3);
      do_round(1'b1, OP_PUSH, 8'($urandom_range(0, 255)), 1'b0, OP_NONE, 8'h00);
    end
    s0 = push_stb_cycles;
    do_round(1'b1, OP_PUSH, CH_MINUS, 1'b0, OP_NONE, 8'h00);
    check("full_push_no_stb", 32'(push_stb_cycles - s0), 32'(0));
    check("full_occ", 32'(OCC), 32'(DEPTH));

    // Reset while a push is stuck in WAIT.
    do_round(1'b0, OP_NONE, 8'h00, 1'b1, OP_POP, 8'h00);
    push_delay = 50;
    A_STB = 1'b1; A_OP = OP_PUSH; A_DAT = 8'h55; A_LOCK = 1'b0;
    repeat (3) @(posedge CLK);
    @(negedge CLK);
    check("wait_state", 32'(DBG_STATE), 32'(WAIT));
    check("wait_push_stb", 32'(S_PUSH_STB), 32'(1));
    #2 RST_N = 1'b0;
    #1;
    check_outputs_zero("midreset");
    A_STB = 1'b0;
    mstk.delete();
    m_last = 1'b1;
    push_delay = 2;
    repeat (2) @(posedge CLK);
    #3 RST_N = 1'b1;
    @(posedge CLK); #1;
    do_round(1'b1, OP_PEEK, 8'h00, 1'b1, OP_PEEK, 8'h00);

    for (int r = 0; r < 80; r++) begin
      int kind;
      kind = $urandom_range(0, 2);
      push_delay = $urandom_range(1, 3);
      do_round(kind != 1, 2'($urandom_range(1, 3)), 8'($urandom_range(0, 255)),
               kind != 0, 2'($urandom_range(1, 3)), 8'($urandom_range(0, 255)));
    end

    repeat (5) @(posedge CLK);
    check("scoreboard_drained", 32'(exp_q.size()), 32'(0));
    check("final_occ", 32'(OCC), 32'(mstk.size()));
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
